// File: rtl/wb_arb_stage_pkg.sv
// Shared types for the writeback/arbitration stage: data-mux codes, load sizes,
// pipeline writeback request and late-result entry.
package wb_arb_stage_pkg;

  // Request payloads are sized for the widest supported core; the stage truncates.
  localparam int unsigned REQ_DATA_W = 64;
  localparam int unsigned REQ_ADDR_W = 8;

  typedef enum logic [1:0] {
    WDATA_ALU = 2'd0,
    WDATA_MEM = 2'd1,
    WDATA_PC4 = 2'd2
  } wdata_mux_e;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2,
    LSU_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic                  reg_we;
    logic [REQ_ADDR_W-1:0] dest_reg;
    wdata_mux_e            wdata_mux;
    logic [REQ_DATA_W-1:0] alu_result;
    logic [REQ_DATA_W-1:0] mem_data;
    logic [REQ_DATA_W-1:0] pc_plus4;
    lsu_size_e             lsu_size;
    logic                  lsu_unsigned;
    logic [2:0]            byte_off;
  } wb_req_t;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] dest;
    logic [REQ_DATA_W-1:0] data;
  } late_entry_t;

  // Byte-offset mask that snaps an access to its natural alignment.
  function automatic logic [2:0] lane_mask(lsu_size_e size);
    case (size)
      LSU_B:   lane_mask = 3'b111;
      LSU_H:   lane_mask = 3'b110;
      LSU_W:   lane_mask = 3'b100;
      default: lane_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/wb_late_fifo.sv
// Small synchronous FIFO buffering late results until they win the write port.
module wb_late_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_arb_stage.sv
// Writeback stage: selects/aligns pipeline writeback data and arbitrates the
// register-file write port against buffered late results.
// WB_LATE_BYPASS_EN: when defined, a late result arriving with the FIFO empty
// and no pipeline write goes straight to the port without a FIFO entry.
module wb_arb_stage
  import wb_arb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned LATE_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_valid_i,
  input  wb_req_t               wb_req_i,
  input  logic                  late_valid_i,
  output logic                  late_ready_o,
  input  logic [ADDR_WIDTH-1:0] late_dest_i,
  input  logic [DATA_WIDTH-1:0] late_wdata_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] dest_reg_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  late_busy_o,
  output logic                  stall_o
);

  localparam int unsigned LANE_W  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned SW      = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W   = $clog2(LATE_DEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(late_entry_t);

  logic                  pw;
  logic                  late_acc;
  logic                  push;
  logic                  pop;
  logic                  byp;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  late_entry_t           push_entry;
  late_entry_t           head;
  lsu_size_e             size_eff;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] dest_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [SW-1:0]         starve_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         starve_q;
  logic                  stall_q;
  logic                  unused_bits;

  assign pw           = wb_valid_i && wb_req_i.reg_we &&
                        (ADDR_WIDTH'(wb_req_i.dest_reg) != '0);
  assign late_ready_o = !fifo_full && !rst_i;
  assign late_acc     = late_valid_i && late_ready_o && (late_dest_i != '0);
  assign push         = late_acc && !byp;
  assign late_busy_o  = !fifo_empty;
  assign we_o         = we_q;
  assign dest_reg_o   = dest_q;
  assign wdata_o      = wdata_q;
  assign stall_o      = stall_q;
  assign unused_bits  = ^{wb_req_i, head, fifo_count};

  always_comb begin
    push_entry      = '0;
    push_entry.dest = REQ_ADDR_W'(late_dest_i);
    push_entry.data = REQ_DATA_W'(late_wdata_i);
  end

  wb_late_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LATE_DEPTH)
  ) u_late_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Load alignment: snap offset to natural lane, shift down, then extend.
  always_comb begin
    size_eff = wb_req_i.lsu_size;
    if (DATA_WIDTH == 32 && size_eff == LSU_D) size_eff = LSU_W;
    lane     = LANE_W'(wb_req_i.byte_off & lane_mask(size_eff));
    mem_word = DATA_WIDTH'(wb_req_i.mem_data);
    shifted  = mem_word >> {lane, 3'b000};
    case (size_eff)
      LSU_B:   load_data = wb_req_i.lsu_unsigned ? DATA_WIDTH'(shifted[7:0])
                                                 : DATA_WIDTH'($signed(shifted[7:0]));
      LSU_H:   load_data = wb_req_i.lsu_unsigned ? DATA_WIDTH'(shifted[15:0])
                                                 : DATA_WIDTH'($signed(shifted[15:0]));
      LSU_W:   load_data = wb_req_i.lsu_unsigned ? DATA_WIDTH'(shifted[31:0])
                                                 : DATA_WIDTH'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

  // Writeback data select; unknown codes fall back to the ALU result.
  always_comb begin
    case (wb_req_i.wdata_mux)
      WDATA_MEM: pipe_data = load_data;
      WDATA_PC4: pipe_data = DATA_WIDTH'(wb_req_i.pc_plus4);
      default:   pipe_data = DATA_WIDTH'(wb_req_i.alu_result);
    endcase
  end

  // Port arbitration: pipeline first, then FIFO head, then (optionally) bypass.
  always_comb begin
    we_d    = 1'b0;
    dest_d  = dest_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    byp     = 1'b0;
    if (pw) begin
      we_d    = 1'b1;
      dest_d  = ADDR_WIDTH'(wb_req_i.dest_reg);
      wdata_d = pipe_data;
    end else if (!fifo_empty) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      dest_d  = ADDR_WIDTH'(head.dest);
      wdata_d = DATA_WIDTH'(head.data);
    end
`ifdef WB_LATE_BYPASS_EN
    else if (late_acc) begin
      byp     = 1'b1;
      we_d    = 1'b1;
      dest_d  = late_dest_i;
      wdata_d = late_wdata_i;
    end
`endif
  end

  // Starvation counter: counts lost cycles with a pending late entry, saturating.
  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (pw && !fifo_empty && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Registered write port and stall request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      dest_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      dest_q   <= dest_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= (starve_d >= SW'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_wb_arb_stage.sv
// Self-checking bench for wb_arb_stage with a write-port scoreboard.
`timescale 1ns/1ps
module tb_wb_arb_stage;
  import wb_arb_stage_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned LD = 2;
  localparam int unsigned SL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wb_valid_i;
  wb_req_t       wb_req_i;
  logic          late_valid_i;
  logic          late_ready_o;
  logic [AW-1:0] late_dest_i;
  logic [DW-1:0] late_wdata_i;
  logic          we_o;
  logic [AW-1:0] dest_reg_o;
  logic [DW-1:0] wdata_o;
  logic          late_busy_o;
  logic          stall_o;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    wdata_mux_e    mux;
    lsu_size_e     sz;
    logic          uns;
    logic [2:0]    off;
    logic [DW-1:0] exp;
  } la_t;

  wr_t           exp_q[$];
  wr_t           mdl_q[$];
  wr_t           mon_e;
  int unsigned   starve;
  logic [DW-1:0] pw_exp;
  logic          mon_en;
  int            vectors;
  int            miscompares;

  always #5 clk_i = ~clk_i;

  wb_arb_stage #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .LATE_DEPTH   (LD),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wb_valid_i   (wb_valid_i),
    .wb_req_i     (wb_req_i),
    .late_valid_i (late_valid_i),
    .late_ready_o (late_ready_o),
    .late_dest_i  (late_dest_i),
    .late_wdata_i (late_wdata_i),
    .we_o         (we_o),
    .dest_reg_o   (dest_reg_o),
    .wdata_o      (wdata_o),
    .late_busy_o  (late_busy_o),
    .stall_o      (stall_o)
  );

  // Scoreboard: each cycle either the expected write appears or the port is idle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (we_o !== 1'b1 || dest_reg_o !== mon_e.dest || wdata_o !== mon_e.data) begin
        miscompares++;
        $display("FAIL sb_write: got we=%b x%0d=%h, expected we=1 x%0d=%h",
                 we_o, dest_reg_o, wdata_o, mon_e.dest, mon_e.data);
      end
    end else if (mon_en) begin
      vectors++;
      if (we_o !== 1'b0) begin
        miscompares++;
        $display("FAIL sb_idle: got we=%b x%0d=%h, expected we=0", we_o, dest_reg_o, wdata_o);
      end
    end
  end

  task automatic idle();
    wb_valid_i   = 1'b0;
    wb_req_i     = '0;
    late_valid_i = 1'b0;
    late_dest_i  = '0;
    late_wdata_i = '0;
    pw_exp       = '0;
  endtask

  // Advance one clock; the reference model predicts the write produced by this edge.
  task automatic tick();
    logic pw;
    logic rdy;
    logic acc;
    logic have;
    logic stall_n;
    wr_t  w;
    have = 1'b0;
    w    = '0;
    pw   = wb_valid_i && wb_req_i.reg_we && (AW'(wb_req_i.dest_reg) != '0);
    rdy  = !rst_i && (mdl_q.size() < LD);
    acc  = late_valid_i && rdy && (late_dest_i != '0);
    if (pw) begin
      w.dest = AW'(wb_req_i.dest_reg);
      w.data = pw_exp;
      have   = 1'b1;
      if (mdl_q.size() > 0 && starve < SL) starve++;
    end else if (mdl_q.size() > 0) begin
      w      = mdl_q.pop_front();
      have   = 1'b1;
      starve = 0;
    end
`ifdef WB_LATE_BYPASS_EN
    else if (acc) begin
      w.dest = late_dest_i;
      w.data = late_wdata_i;
      have   = 1'b1;
      acc    = 1'b0;
    end
`endif
    if (acc) begin
      wr_t e;
      e.dest = late_dest_i;
      e.data = late_wdata_i;
      mdl_q.push_back(e);
    end
    stall_n = (starve >= SL);
    @(posedge clk_i);
    if (rst_i) begin
      exp_q.delete();
      mdl_q.delete();
      starve = 0;
    end else if (have) begin
      exp_q.push_back(w);
    end
    #1;
    if (!rst_i) begin
      vectors++;
      if (stall_o !== stall_n) begin
        miscompares++;
        $display("FAIL model_stall: got %b, expected %b", stall_o, stall_n);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_i        = 1'b1;
    late_valid_i = 1'b1;
    late_dest_i  = AW'(3);
    late_wdata_i = 32'hCAFE_0003;
    wb_valid_i   = 1'b1;
    wb_req_i.reg_we   = 1'b1;
    wb_req_i.dest_reg = 8'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (we_o !== 1'b0 || dest_reg_o !== '0 || wdata_o !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got we=%b x%0d=%h, expected 0/0/0", we_o, dest_reg_o, wdata_o);
      end
      vectors++;
      if (late_busy_o !== 1'b0 || late_ready_o !== 1'b0 || stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flags: got busy=%b ready=%b stall=%b, expected 0/0/0",
                 late_busy_o, late_ready_o, stall_o);
      end
    end
    rst_i = 1'b0;
    idle();
    #1;
    vectors++;
    if (late_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_after: got %b, expected 1", late_ready_o);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_load_align();
    la_t tbl[$];
    tbl.push_back('{WDATA_MEM, LSU_B, 1'b0, 3'd1, 32'h0000_007F});
    tbl.push_back('{WDATA_MEM, LSU_B, 1'b0, 3'd2, 32'hFFFF_FFFF});
    tbl.push_back('{WDATA_MEM, LSU_H, 1'b1, 3'd2, 32'h0000_80FF});
    tbl.push_back('{WDATA_MEM, LSU_H, 1'b0, 3'd3, 32'hFFFF_80FF});
    tbl.push_back('{WDATA_MEM, LSU_B, 1'b1, 3'd0, 32'h0000_0001});
    tbl.push_back('{WDATA_MEM, LSU_W, 1'b0, 3'd1, 32'h80FF_7F01});
    tbl.push_back('{WDATA_MEM, LSU_D, 1'b1, 3'd2, 32'h80FF_7F01});
    tbl.push_back('{WDATA_ALU, LSU_B, 1'b0, 3'd1, 32'h1111_2222});
    tbl.push_back('{WDATA_PC4, LSU_B, 1'b0, 3'd1, 32'h0000_1004});
    tbl.push_back('{wdata_mux_e'(2'd3), LSU_B, 1'b0, 3'd1, 32'h1111_2222});
    foreach (tbl[i]) begin
      idle();
      wb_valid_i            = 1'b1;
      wb_req_i.reg_we       = 1'b1;
      wb_req_i.dest_reg     = 8'(10 + i);
      wb_req_i.wdata_mux    = tbl[i].mux;
      wb_req_i.alu_result   = 64'hFFFF_0000_1111_2222;
      wb_req_i.mem_data     = 64'hDEAD_BEEF_80FF_7F01;
      wb_req_i.pc_plus4     = 64'h0000_0000_0000_1004;
      wb_req_i.lsu_size     = tbl[i].sz;
      wb_req_i.lsu_unsigned = tbl[i].uns;
      wb_req_i.byte_off     = tbl[i].off;
      pw_exp                = tbl[i].exp;
      tick();
      vectors++;
      if (we_o !== 1'b1 || dest_reg_o !== AW'(10 + i) || wdata_o !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL load_align[%0d]: got we=%b x%0d=%h, expected we=1 x%0d=%h",
                 i, we_o, dest_reg_o, wdata_o, 10 + i, tbl[i].exp);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    idle();
    wb_valid_i          = 1'b1;
    wb_req_i.reg_we     = 1'b1;
    wb_req_i.dest_reg   = 8'd0;
    wb_req_i.alu_result = 64'h55;
    pw_exp              = 32'h55;
    tick();
    vectors++;
    if (we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_pipe: got we=%b, expected 0", we_o);
    end
    wb_req_i.reg_we   = 1'b0;
    wb_req_i.dest_reg = 8'd4;
    tick();
    vectors++;
    if (we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL no_reg_we: got we=%b, expected 0", we_o);
    end
    idle();
    late_valid_i = 1'b1;
    late_dest_i  = '0;
    late_wdata_i = 32'h0000_ABCD;
    tick();
    idle();
    vectors++;
    if (late_busy_o !== 1'b0 || we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_late: got busy=%b we=%b, expected 0/0", late_busy_o, we_o);
    end
    tick();
    vectors++;
    if (late_busy_o !== 1'b0 || we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_late_later: got busy=%b we=%b, expected 0/0", late_busy_o, we_o);
    end
  endtask

  task automatic test_conflict();
    idle();
    wb_valid_i          = 1'b1;
    wb_req_i.reg_we     = 1'b1;
    wb_req_i.dest_reg   = 8'd5;
    wb_req_i.wdata_mux  = WDATA_ALU;
    wb_req_i.alu_result = 64'hA5A5_0005;
    pw_exp              = 32'hA5A5_0005;
    late_valid_i        = 1'b1;
    late_dest_i         = AW'(7);
    late_wdata_i        = 32'h7777_0007;
    tick();
    idle();
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(5) || wdata_o !== 32'hA5A5_0005) begin
      miscompares++;
      $display("FAIL conflict_pipe: got we=%b x%0d=%h, expected x5=a5a50005", we_o, dest_reg_o, wdata_o);
    end
    tick();
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(7) || wdata_o !== 32'h7777_0007) begin
      miscompares++;
      $display("FAIL conflict_late: got we=%b x%0d=%h, expected x7=77770007", we_o, dest_reg_o, wdata_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lidx;
    lidx = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      wb_valid_i          = 1'b1;
      wb_req_i.reg_we     = 1'b1;
      wb_req_i.dest_reg   = 8'(k + 1);
      wb_req_i.alu_result = 64'(32'h5000_0000 + k);
      pw_exp              = 32'h5000_0000 + DW'(k);
      late_valid_i        = 1'b1;
      late_dest_i         = AW'(20 + lidx);
      late_wdata_i        = 32'h1000_0000 + DW'(lidx);
      vectors++;
      if (late_ready_o !== (k < 2)) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: got %b, expected %b", k, late_ready_o, (k < 2));
      end
      tick();
      if (k < 2) lidx++;
      vectors++;
      if (we_o !== 1'b1 || dest_reg_o !== AW'(k + 1)) begin
        miscompares++;
        $display("FAIL bp_pipe[%0d]: got we=%b x%0d, expected x%0d", k, we_o, dest_reg_o, k + 1);
      end
      vectors++;
      if (stall_o !== (k >= 4) || late_busy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: got stall=%b busy=%b, expected %b/1", k, stall_o, late_busy_o, (k >= 4));
      end
    end
    wb_valid_i = 1'b0;
    wb_req_i   = '0;
    vectors++;
    if (late_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain_ready0: got %b, expected 0", late_ready_o);
    end
    tick();
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(20) || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain0: got we=%b x%0d stall=%b, expected x20 stall=0", we_o, dest_reg_o, stall_o);
    end
    vectors++;
    if (late_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain_ready1: got %b, expected 1", late_ready_o);
    end
    tick();
    late_valid_i = 1'b0;
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(21) || late_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain1: got we=%b x%0d busy=%b, expected x21 busy=1", we_o, dest_reg_o, late_busy_o);
    end
    tick();
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(22) || wdata_o !== 32'h1000_0002 || late_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain2: got we=%b x%0d=%h busy=%b, expected x22=10000002 busy=0",
               we_o, dest_reg_o, wdata_o, late_busy_o);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    late_valid_i = 1'b1;
    late_dest_i  = AW'(9);
    late_wdata_i = 32'h0000_1234;
    tick();
    idle();
`ifdef WB_LATE_BYPASS_EN
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(9) || wdata_o !== 32'h1234 || late_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_n1: got we=%b x%0d=%h busy=%b, expected x9=1234 busy=0",
               we_o, dest_reg_o, wdata_o, late_busy_o);
    end
`else
    vectors++;
    if (we_o !== 1'b0 || late_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL nobypass_n1: got we=%b busy=%b, expected 0/1", we_o, late_busy_o);
    end
    tick();
    vectors++;
    if (we_o !== 1'b1 || dest_reg_o !== AW'(9) || wdata_o !== 32'h1234) begin
      miscompares++;
      $display("FAIL nobypass_n2: got we=%b x%0d=%h, expected x9=1234", we_o, dest_reg_o, wdata_o);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      idle();
      wb_valid_i          = 1'b1;
      wb_req_i.reg_we     = 1'b1;
      wb_req_i.dest_reg   = 8'(2 + k);
      wb_req_i.alu_result = 64'(32'h6000_0000 + k);
      pw_exp              = 32'h6000_0000 + DW'(k);
      late_valid_i        = 1'b1;
      late_dest_i         = AW'(23 + k);
      late_wdata_i        = 32'h2300_0000 + DW'(k);
      tick();
    end
    vectors++;
    if (late_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy_before: got %b, expected 1", late_busy_o);
    end
    idle();
    rst_i      = 1'b1;
    wb_valid_i = 1'b1;
    wb_req_i.reg_we   = 1'b1;
    wb_req_i.dest_reg = 8'd6;
    tick();
    vectors++;
    if (we_o !== 1'b0 || late_busy_o !== 1'b0 || dest_reg_o !== '0 || wdata_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid: got we=%b busy=%b x%0d=%h, expected all 0", we_o, late_busy_o, dest_reg_o, wdata_o);
    end
    rst_i = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (we_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_after[%0d]: got we=%b, expected 0", k, we_o);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    starve      = 0;
    mon_en      = 1'b0;
    rst_i       = 1'b1;
    idle();
    test_reset();
    test_load_align();
    test_x0();
    test_conflict();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    tick();
    tick();
    @(negedge clk_i);
    #1;
    vectors++;
    if (exp_q.size() != 0 || mdl_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_end: got %0d pending writes, expected 0", exp_q.size() + mdl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
